// File: rtl/ultrasonic_sensor_trigger_pkg.sv
// ultrasonic_sensor_trigger_pkg: shared HC-SR04 state encodings and 50 MHz default timings
package ultrasonic_sensor_trigger_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;
  localparam int DEF_TRIG_CYCLES         = 500;
  localparam int DEF_RISE_TIMEOUT_CYCLES = 50_000;
  localparam int DEF_ECHO_TIMEOUT_CYCLES = 1_900_000;
  localparam int DEF_PERIOD_CYCLES       = 3_000_000;
  localparam int DEF_CNT_W               = 22;
endpackage

// File: rtl/ultrasonic_sensor_trigger_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser, asynchronously cleared to 0
//   Clk_i   destination clock
//   Reset_i asynchronous active-low reset
//   d       asynchronous input
//   q       synchronised output, two clocks behind d
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ultrasonic_sensor_trigger.sv
// ultrasonic_sensor_trigger: HC-SR04 trigger pulse generator, measurement scheduler and echo supervisor
//   Clk_i          system clock
//   Reset_i        asynchronous active-low reset
//   Enable_i       continuous measurement while high
//   Start_i        one-cycle single-measurement request
//   Echo_i         raw asynchronous echo pin
//   Trigger_o      trigger pulse to sensor
//   Busy_o         measurement cycle in progress
//   Done_o         one-cycle pulse on a valid echo fall
//   Timeout_o      one-cycle pulse on rise or echo timeout
//   Timeout_kind_o 0 = no echo rise, 1 = echo too long; held until next timeout
module ultrasonic_sensor_trigger
  import ultrasonic_sensor_trigger_pkg::*;
#(
  parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
  parameter int RISE_TIMEOUT_CYCLES = DEF_RISE_TIMEOUT_CYCLES,
  parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
  parameter int PERIOD_CYCLES       = DEF_PERIOD_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Enable_i,
  input  logic Start_i,
  input  logic Echo_i,
  output logic Trigger_o,
  output logic Busy_o,
  output logic Done_o,
  output logic Timeout_o,
  output logic Timeout_kind_o
);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, pcnt, pcnt_nx;
  logic             echo_s, echo_q, rise, fall;
  logic             done_nx, to_nx, kind_nx;
  sync_2ff #(.W(1)) u_sync (
    .Clk_i  (Clk_i),
    .Reset_i(Reset_i),
    .d      (Echo_i),
    .q      (echo_s)
  );
  // echo_q tracks echo_s in every state, so an echo already high on entry to WAIT_RISE is not a rise
  assign rise = echo_s & ~echo_q;
  assign fall = ~echo_s & echo_q;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    pcnt_nx  = (pcnt == PER_LAST) ? pcnt : pcnt + 1'b1;
    done_nx  = 1'b0;
    to_nx    = 1'b0;
    kind_nx  = Timeout_kind_o;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        pcnt_nx = '0;
        if (Enable_i || Start_i) state_nx = TRIG;
      end
      TRIG: if (cnt == TRIG_LAST) begin
        state_nx = WAIT_RISE;
        cnt_nx   = '0;
      end
      WAIT_RISE: if (rise) begin
        state_nx = WAIT_FALL;
        cnt_nx   = '0;
      end else if (cnt == RISE_LAST) begin
        state_nx = HOLDOFF;
        to_nx    = 1'b1;
        kind_nx  = 1'b0;
      end
      WAIT_FALL: if (fall) begin
        state_nx = HOLDOFF;
        done_nx  = 1'b1;
      end else if (cnt == ECHO_LAST) begin
        state_nx = HOLDOFF;
        to_nx    = 1'b1;
        kind_nx  = 1'b1;
      end
      HOLDOFF: begin
        cnt_nx = '0;
        // pcnt was 0 on the first TRIG cycle, so leaving here keeps trigger rises exactly one period apart
        if (pcnt == PER_LAST) begin
          state_nx = Enable_i ? TRIG : IDLE;
          pcnt_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      pcnt           <= '0;
      echo_q         <= 1'b0;
      Trigger_o      <= 1'b0;
      Busy_o         <= 1'b0;
      Done_o         <= 1'b0;
      Timeout_o      <= 1'b0;
      Timeout_kind_o <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pcnt           <= pcnt_nx;
      echo_q         <= echo_s;
      Trigger_o      <= state_nx == TRIG;
      Busy_o         <= state_nx != IDLE;
      Done_o         <= done_nx;
      Timeout_o      <= to_nx;
      Timeout_kind_o <= kind_nx;
    end
  end
endmodule

// File: tb/tb_ultrasonic_sensor_trigger.sv
// tb_ultrasonic_sensor_trigger: scoreboard bench for the HC-SR04 trigger/supervisor block
module tb_ultrasonic_sensor_trigger;
  localparam int TRIG = 10, RISE_TO = 50, ECHO_TO = 200, PER = 400;
  localparam int EV_TR_RISE = 0, EV_TR_FALL = 1, EV_DONE = 2, EV_TO0 = 3, EV_TO1 = 4, EV_BUSY_FALL = 5;
  typedef struct {
    int code;
    int cyc;
  } ev_t;
  logic Clk_i, Reset_i, Enable_i, Start_i, Echo_i;
  logic Trigger_o, Busy_o, Done_o, Timeout_o, Timeout_kind_o;
  int   cyc;
  int   n_vec, n_err;
  ev_t  q[$];
  ultrasonic_sensor_trigger #(
    .TRIG_CYCLES        (TRIG),
    .RISE_TIMEOUT_CYCLES(RISE_TO),
    .ECHO_TIMEOUT_CYCLES(ECHO_TO),
    .PERIOD_CYCLES      (PER)
  ) dut (
    .Clk_i         (Clk_i),
    .Reset_i       (Reset_i),
    .Enable_i      (Enable_i),
    .Start_i       (Start_i),
    .Echo_i        (Echo_i),
    .Trigger_o     (Trigger_o),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Timeout_o     (Timeout_o),
    .Timeout_kind_o(Timeout_kind_o)
  );
  initial assert (PER > TRIG + RISE_TO + ECHO_TO + 8) else $fatal(1, "FAIL cfg: illegal period %0d", PER);
  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end
  initial begin
    cyc = 0;
    forever @(posedge Clk_i) cyc++;
  end
  task automatic expect_ev(input int code, input int c);
    ev_t e;
    e.code = code;
    e.cyc  = c;
    q.push_back(e);
  endtask
  task automatic chk(input int code);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected code=%0d at cyc=%0d, required none", code, cyc);
    end else begin
      e = q.pop_front();
      if (e.code != code || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got code=%0d cyc=%0d, required code=%0d cyc=%0d", code, cyc, e.code, e.cyc);
      end
    end
  endtask
  task automatic chk_out(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, required %b at cyc=%0d", name, got, want, cyc);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk_out({tag, " Trigger_o"}, Trigger_o, 1'b0);
    chk_out({tag, " Busy_o"}, Busy_o, 1'b0);
    chk_out({tag, " Done_o"}, Done_o, 1'b0);
    chk_out({tag, " Timeout_o"}, Timeout_o, 1'b0);
    chk_out({tag, " Timeout_kind_o"}, Timeout_kind_o, 1'b0);
  endtask
  task automatic at(input int c);
    while (cyc < c) @(negedge Clk_i);
  endtask
  // monitor: every output event is popped against the scoreboard in a fixed per-cycle order
  initial begin
    logic trig_q, busy_q;
    trig_q = 1'b0;
    busy_q = 1'b0;
    forever begin
      @(negedge Clk_i);
      if (Trigger_o && !trig_q) chk(EV_TR_RISE);
      if (!Trigger_o && trig_q) chk(EV_TR_FALL);
      if (Done_o) chk(EV_DONE);
      if (Timeout_o) chk(EV_TO0 + int'(Timeout_kind_o));
      if (!Busy_o && busy_q) chk(EV_BUSY_FALL);
      trig_q = Trigger_o;
      busy_q = Busy_o;
    end
  end
  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_i = 1'b0;
    Enable_i = 1'b0;
    Start_i = 1'b0;
    Echo_i = 1'b0;
    #3 chk_idle_outputs("reset");
    at(2); Reset_i = 1'b1;
    // 1: single shot with a 100-cycle echo
    expect_ev(EV_TR_RISE, 6); expect_ev(EV_TR_FALL, 16); expect_ev(EV_DONE, 133); expect_ev(EV_BUSY_FALL, 406);
    at(5); Start_i = 1'b1;
    at(6); Start_i = 1'b0;
    at(30); Echo_i = 1'b1;
    at(130); Echo_i = 1'b0;
    // 2: no echo at all
    expect_ev(EV_TR_RISE, 421); expect_ev(EV_TR_FALL, 431); expect_ev(EV_TO0, 481); expect_ev(EV_BUSY_FALL, 821);
    at(420); Start_i = 1'b1;
    at(421); Start_i = 1'b0;
    // 3: over-long echo, plus a Start_i while busy that must be ignored
    expect_ev(EV_TR_RISE, 841); expect_ev(EV_TR_FALL, 851); expect_ev(EV_TO1, 1073); expect_ev(EV_BUSY_FALL, 1241);
    at(840); Start_i = 1'b1;
    at(841); Start_i = 1'b0;
    at(870); Echo_i = 1'b1;
    at(1100); Start_i = 1'b1;
    at(1101); Start_i = 1'b0;
    at(1170); Echo_i = 1'b0;
    at(1200); chk_out("kind held", Timeout_kind_o, 1'b1);
    // 4: continuous mode, echo / timeout / echo, enable dropped during the third WAIT_FALL
    expect_ev(EV_TR_RISE, 1261); expect_ev(EV_TR_FALL, 1271); expect_ev(EV_DONE, 1338);
    expect_ev(EV_TR_RISE, 1661); expect_ev(EV_TR_FALL, 1671); expect_ev(EV_TO0, 1721);
    expect_ev(EV_TR_RISE, 2061); expect_ev(EV_TR_FALL, 2071); expect_ev(EV_DONE, 2153);
    expect_ev(EV_BUSY_FALL, 2461);
    at(1260); Enable_i = 1'b1;
    at(1285); Echo_i = 1'b1;
    at(1335); Echo_i = 1'b0;
    at(2085); Echo_i = 1'b1;
    at(2100); Enable_i = 1'b0;
    at(2150); Echo_i = 1'b0;
    // 5: echo stuck high before the trigger, extra starts while busy
    expect_ev(EV_TR_RISE, 2501); expect_ev(EV_TR_FALL, 2511); expect_ev(EV_TO0, 2561); expect_ev(EV_BUSY_FALL, 2901);
    at(2480); Echo_i = 1'b1;
    at(2500); Start_i = 1'b1;
    at(2501); Start_i = 1'b0;
    at(2520); Start_i = 1'b1;
    at(2521); Start_i = 1'b0;
    at(2600); Start_i = 1'b1;
    at(2601); Start_i = 1'b0;
    at(2910); Echo_i = 1'b0;
    // 6: reset in the fourth trigger cycle, then a fresh full-length trigger
    expect_ev(EV_TR_RISE, 2951); expect_ev(EV_TR_FALL, 2955); expect_ev(EV_BUSY_FALL, 2955);
    expect_ev(EV_TR_RISE, 2971); expect_ev(EV_TR_FALL, 2981); expect_ev(EV_TO0, 3031); expect_ev(EV_BUSY_FALL, 3371);
    at(2950); Start_i = 1'b1;
    at(2951); Start_i = 1'b0;
    at(2954); #2 Reset_i = 1'b0;
    #1 chk_idle_outputs("mid reset");
    at(2960); Reset_i = 1'b1;
    at(2970); Start_i = 1'b1;
    at(2971); Start_i = 1'b0;
    at(3400);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing event: got nothing, required code=%0d cyc=%0d", e.code, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
